// File: rtl/medfilt_sram_arb.sv
// medfilt_sram_arb: two-client arbiter in front of the median-filter frame SRAM.
//
// Client 0 (line fetch) and client 1 (result writeback) share the single SRAM
// request slot. Arbitration is round-robin. A client may also hold a bounded
// burst lock, which keeps the grant for up to MAX_BURST consecutive cycles while
// the other client waits. Read data returns through a registered one-cycle path.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   ck_req/ck_lock    request valid / ask to keep the grant next cycle (k = 0, 1)
//   ck_we/ck_be       write select / byte enables (be ignored on reads)
//   ck_addr/ck_wdata  word address / write data
//   ck_gnt            combinational accept for this cycle
//   ck_rvalid/rdata   registered read response, rdata held between reads
//   sram_*            SRAM drive: csn active low, separate read/write address,
//                     byte write enables, write data; sram_dout is comb. read data
module medfilt_sram_arb #(
    parameter int unsigned DW        = 64,
    parameter int unsigned BW        = 8,
    parameter int unsigned AW        = 21,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic          clk,
    input  logic          rst_n,

    input  logic          c0_req,
    input  logic          c0_lock,
    input  logic          c0_we,
    input  logic [BW-1:0] c0_be,
    input  logic [AW-1:0] c0_addr,
    input  logic [DW-1:0] c0_wdata,
    output logic          c0_gnt,
    output logic          c0_rvalid,
    output logic [DW-1:0] c0_rdata,

    input  logic          c1_req,
    input  logic          c1_lock,
    input  logic          c1_we,
    input  logic [BW-1:0] c1_be,
    input  logic [AW-1:0] c1_addr,
    input  logic [DW-1:0] c1_wdata,
    output logic          c1_gnt,
    output logic          c1_rvalid,
    output logic [DW-1:0] c1_rdata,

    output logic          sram_csn,
    output logic [AW-1:0] sram_adri,
    output logic [AW-1:0] sram_adro,
    output logic [BW-1:0] sram_wen,
    output logic [DW-1:0] sram_din,
    input  logic [DW-1:0] sram_dout
);

    // Counter only needs to reach MAX_BURST-1.
    localparam int unsigned CW = (MAX_BURST > 2) ? $clog2(MAX_BURST) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_BURST - 1);

    logic          last_q;   // last-granted client
    logic [CW-1:0] cnt_q;    // consecutive locked grants
    logic          gq_q;     // a grant happened last cycle

    logic          last_lock;
    logic          keep;
    logic          any_gnt;
    logic          sel;      // granted client index
    logic          sel_we;
    logic          sel_lock;
    logic [BW-1:0] sel_be;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;

    assign last_lock = last_q ? c1_lock : c0_lock;
    // The last winner keeps the slot on a tie only while its burst is still under the cap.
    assign keep      = gq_q & last_lock & (cnt_q < CNT_MAX);

    always_comb begin
        c0_gnt = 1'b0;
        c1_gnt = 1'b0;
        if (rst_n) begin
            if (c0_req && c1_req) begin
                c1_gnt = keep ? last_q : ~last_q;
                c0_gnt = ~c1_gnt;
            end else begin
                c0_gnt = c0_req;
                c1_gnt = c1_req;
            end
        end
    end

    assign any_gnt   = c0_gnt | c1_gnt;
    assign sel       = c1_gnt;
    assign sel_we    = sel ? c1_we    : c0_we;
    assign sel_lock  = sel ? c1_lock  : c0_lock;
    assign sel_be    = sel ? c1_be    : c0_be;
    assign sel_addr  = sel ? c1_addr  : c0_addr;
    assign sel_wdata = sel ? c1_wdata : c0_wdata;

    // SRAM bus is zeroed when idle so unused fields never toggle.
    always_comb begin
        sram_csn  = ~any_gnt;
        sram_adri = '0;
        sram_adro = '0;
        sram_wen  = '0;
        sram_din  = '0;
        if (any_gnt) begin
            if (sel_we) begin
                sram_adro = sel_addr;
                sram_wen  = sel_be;
                sram_din  = sel_wdata;
            end else begin
                sram_adri = sel_addr;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q    <= 1'b1;
            cnt_q     <= '0;
            gq_q      <= 1'b0;
            c0_rvalid <= 1'b0;
            c1_rvalid <= 1'b0;
            c0_rdata  <= '0;
            c1_rdata  <= '0;
        end else begin
            if (any_gnt) begin
                if ((sel == last_q) && gq_q && sel_lock) begin
                    cnt_q <= (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + 1'b1;
                end else begin
                    cnt_q <= '0;
                end
                last_q <= sel;
                gq_q   <= 1'b1;
            end else begin
                cnt_q <= '0;
                gq_q  <= 1'b0;
            end

            c0_rvalid <= c0_gnt & ~c0_we;
            c1_rvalid <= c1_gnt & ~c1_we;
            if (c0_gnt && !c0_we) c0_rdata <= sram_dout;
            if (c1_gnt && !c1_we) c1_rdata <= sram_dout;
        end
    end

endmodule
